// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_pkg
// Description : Shared definitions for the instruction cache and its bench.
//               Line geometry (4 x 32-bit words, 16 bytes), offset and
//               word-select widths, FSM state encodings and a helper that
//               forms the line-aligned base of a byte address.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

    localparam int c_addr_bits      = 32;
    localparam int c_data_bits      = 32;
    localparam int c_words_per_line = 4;
    localparam int c_word_sel_bits  = 2;
    localparam int c_offset_bits    = 4;

    // Two-state controller: lookup / line refill.
    localparam logic [0:0] c_st_idle   = 1'b0;
    localparam logic [0:0] c_st_refill = 1'b1;

    // Line-aligned base address: byte offset bits forced to zero.
    function automatic logic [c_addr_bits-1:0] line_base(input logic [c_addr_bits-1:0] addr);
        return {addr[c_addr_bits-1:c_offset_bits], {c_offset_bits{1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_store.sv
`default_nettype none
// ============================================================================
// Module      : icache_store
// Description : Valid / tag / data storage for the direct-mapped icache.
//               Combinational read port, synchronous write port, valid bits
//               cleared asynchronously by reset and synchronously by flush.
//               Tag and data arrays carry no reset.
// Ports       : clk, reset          - clock, asynchronous active-low reset
//               i_rd_index/i_rd_word - lookup address
//               o_rd_valid/o_rd_tag/o_rd_data - lookup result
//               i_wr_en/i_wr_index/i_wr_word/i_wr_data - refill word write
//               i_fill_done/i_fill_tag - tag write at i_wr_index
//               i_set_valid          - mark line i_wr_index valid
//               i_clear_all          - invalidate every line
// Revision    : 1.0 - initial release
// ============================================================================
module icache_store
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = c_addr_bits - INDEX_BITS - c_offset_bits
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [INDEX_BITS-1:0]      i_rd_index,
    input  logic [c_word_sel_bits-1:0] i_rd_word,
    output logic                       o_rd_valid,
    output logic [TAG_BITS-1:0]        o_rd_tag,
    output logic [c_data_bits-1:0]     o_rd_data,
    input  logic                       i_wr_en,
    input  logic [INDEX_BITS-1:0]      i_wr_index,
    input  logic [c_word_sel_bits-1:0] i_wr_word,
    input  logic [c_data_bits-1:0]     i_wr_data,
    input  logic                       i_fill_done,
    input  logic [TAG_BITS-1:0]        i_fill_tag,
    input  logic                       i_set_valid,
    input  logic                       i_clear_all
);

    localparam int c_lines = 1 << INDEX_BITS;
    localparam int c_words = 1 << (INDEX_BITS + c_word_sel_bits);

    logic [c_lines-1:0]     r_valid;
    logic [TAG_BITS-1:0]    r_tag  [0:c_lines-1];
    logic [c_data_bits-1:0] r_data [0:c_words-1];

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_data  = r_data[{i_rd_index, i_rd_word}];

    // Flush wins over a same-edge set so a flushed fill never turns valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
        end else if (i_clear_all) begin
            r_valid <= '0;
        end else if (i_set_valid) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_data[{i_wr_index, i_wr_word}] <= i_wr_data;
        end
        if (i_fill_done) begin
            r_tag[i_wr_index] <= i_fill_tag;
        end
    end

endmodule
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module      : icache
// Description : Direct-mapped blocking instruction cache, 2^INDEX_BITS lines
//               of 4 x 32-bit words. Hits return data combinationally; a
//               miss stalls the fetch stage and refills the whole line from
//               memory (4 in-order beats) before the lookup is retried.
// Ports       : clk        - clock (rising edge)
//               reset      - asynchronous active-low reset
//               cpu_req    - fetch request valid
//               cpu_addr   - fetch byte address (bits [1:0] ignored)
//               flush      - invalidate all lines (one-cycle pulse)
//               cpu_rdata  - fetched instruction, 0 unless a hit
//               cpu_stall  - fetch not satisfied this cycle
//               mem_req    - one-cycle pulse starting a line refill
//               mem_addr   - line-aligned refill address, held during refill
//               mem_rvalid - refill beat valid
//               mem_rdata  - refill beat data, words 0..3 in order
// Revision    : 1.0 - initial release
// ============================================================================
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cpu_req,
    input  logic [c_addr_bits-1:0] cpu_addr,
    input  logic                   flush,
    output logic [c_data_bits-1:0] cpu_rdata,
    output logic                   cpu_stall,
    output logic                   mem_req,
    output logic [c_addr_bits-1:0] mem_addr,
    input  logic                   mem_rvalid,
    input  logic [c_data_bits-1:0] mem_rdata
);

    localparam int c_tag_bits = c_addr_bits - INDEX_BITS - c_offset_bits;

    logic [0:0]                 r_state;
    logic [0:0]                 w_next_state;
    logic [c_word_sel_bits-1:0] r_beat_cnt;
    logic                       r_mem_req;
    logic [c_addr_bits-1:0]     r_mem_addr;
    logic                       r_flush_pend;

    logic                       w_start_refill;
    logic                       w_beat_wr;
    logic                       w_fill_last;
    logic                       w_set_valid;
    logic                       w_hit;

    logic [INDEX_BITS-1:0]      w_lookup_index;
    logic [c_word_sel_bits-1:0] w_lookup_word;
    logic [c_tag_bits-1:0]      w_lookup_tag;
    logic [INDEX_BITS-1:0]      w_fill_index;
    logic [c_tag_bits-1:0]      w_fill_tag;

    logic                       w_rd_valid;
    logic [c_tag_bits-1:0]      w_rd_tag;
    logic [c_data_bits-1:0]     w_rd_data;

    // Byte-within-word bits play no part in an instruction fetch.
    logic                       w_unused_addr_bits;
    assign w_unused_addr_bits = ^cpu_addr[1:0];

    assign w_lookup_index = cpu_addr[INDEX_BITS+c_offset_bits-1:c_offset_bits];
    assign w_lookup_word  = cpu_addr[c_offset_bits-1:2];
    assign w_lookup_tag   = cpu_addr[c_addr_bits-1:INDEX_BITS+c_offset_bits];

    // Refill target comes from the latched miss address, so cpu_addr may
    // wander while the line is being fetched.
    assign w_fill_index   = r_mem_addr[INDEX_BITS+c_offset_bits-1:c_offset_bits];
    assign w_fill_tag     = r_mem_addr[c_addr_bits-1:INDEX_BITS+c_offset_bits];

    assign w_hit = w_rd_valid && (w_rd_tag == w_lookup_tag);

    // A line whose refill saw a flush (earlier or on the final beat) keeps
    // its data but is never marked valid.
    assign w_set_valid = w_fill_last && !r_flush_pend && !flush;

    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (cpu_req && !w_hit) begin
                    w_next_state = c_st_refill;
                end
            end
            c_st_refill: begin
                if (mem_rvalid && (r_beat_cnt == 2'd3)) begin
                    w_next_state = c_st_idle;
                end
            end
            default: w_next_state = c_st_idle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        cpu_stall      = 1'b0;
        cpu_rdata      = '0;
        w_start_refill = 1'b0;
        w_beat_wr      = 1'b0;
        w_fill_last    = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (cpu_req) begin
                    if (w_hit) begin
                        cpu_rdata = w_rd_data;
                    end else begin
                        cpu_stall      = 1'b1;
                        w_start_refill = 1'b1;
                    end
                end
            end
            c_st_refill: begin
                cpu_stall   = 1'b1;
                w_beat_wr   = mem_rvalid;
                w_fill_last = mem_rvalid && (r_beat_cnt == 2'd3);
            end
            default: begin
                cpu_stall = 1'b1;
            end
        endcase
    end

    // ---------------- Refill datapath ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_beat_cnt   <= '0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            r_mem_req <= w_start_refill;
            if (w_start_refill) begin
                r_mem_addr <= line_base(cpu_addr);
            end
            if (w_fill_last) begin
                r_beat_cnt <= '0;
            end else if (w_beat_wr) begin
                r_beat_cnt <= r_beat_cnt + 2'd1;
            end
            if (w_fill_last) begin
                r_flush_pend <= 1'b0;
            end else if (flush && (r_state == c_st_refill)) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    icache_store #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (c_tag_bits)
    ) u_store (
        .clk         (clk),
        .reset       (reset),
        .i_rd_index  (w_lookup_index),
        .i_rd_word   (w_lookup_word),
        .o_rd_valid  (w_rd_valid),
        .o_rd_tag    (w_rd_tag),
        .o_rd_data   (w_rd_data),
        .i_wr_en     (w_beat_wr),
        .i_wr_index  (w_fill_index),
        .i_wr_word   (r_beat_cnt),
        .i_wr_data   (mem_rdata),
        .i_fill_done (w_fill_last),
        .i_fill_tag  (w_fill_tag),
        .i_set_valid (w_set_valid),
        .i_clear_all (flush)
    );

endmodule
`default_nettype wire
